// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM (BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA); ports: clock, reset (async, active-low), opcode/zero/mem_pronta in; datapath control strobes, estado, instrucao_concluida out
module controle_multiciclo #(
  parameter logic [2:0] TIPO_R = 3'b000,
  parameter logic [2:0] ADDI   = 3'b001,
  parameter logic [2:0] SLTI   = 3'b010,
  parameter logic [2:0] LW     = 3'b011,
  parameter logic [2:0] SW     = 3'b100,
  parameter logic [2:0] BEQ    = 3'b101,
  parameter logic [2:0] J      = 3'b110,
  parameter logic [2:0] JAL    = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_pronta,
  output logic       pc_escrita,
  output logic       ir_escrita,
  output logic       reg_escrita,
  output logic       mem_leitura,
  output logic       mem_escrita,
  output logic       ula_src,
  output logic       iord,
  output logic       sign_zero,
  output logic [1:0] ula_opcode,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_fonte,
  output logic [2:0] estado,
  output logic       instrucao_concluida
);
  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4
  } estado_t;
  estado_t estado_q, estado_d;
  logic jump, mem_op, reg_op;
  assign jump   = (opcode == J) || (opcode == JAL);
  assign mem_op = (opcode == LW) || (opcode == SW);
  assign reg_op = (opcode == TIPO_R) || (opcode == ADDI) || (opcode == SLTI);
  assign estado = estado_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) estado_q <= BUSCA;
    else        estado_q <= estado_d;
  // Outputs are gated by reset so the held BUSCA state does not request a fetch while reset is asserted.
  always_comb begin
    estado_d            = BUSCA;
    pc_escrita          = 1'b0;
    ir_escrita          = 1'b0;
    reg_escrita         = 1'b0;
    mem_leitura         = 1'b0;
    mem_escrita         = 1'b0;
    ula_src             = 1'b0;
    iord                = 1'b0;
    sign_zero           = 1'b1;
    ula_opcode          = 2'd0;
    reg_dest            = 2'd0;
    mem_to_reg          = 2'd0;
    pc_fonte            = 2'd0;
    instrucao_concluida = 1'b0;
    if (reset)
      case (estado_q)
        BUSCA: begin
          mem_leitura = 1'b1;
          ir_escrita  = mem_pronta;
          pc_escrita  = mem_pronta;
          estado_d    = mem_pronta ? DECODIFICA : BUSCA;
        end
        DECODIFICA: begin
          pc_escrita          = jump;
          pc_fonte            = jump ? 2'd2 : 2'd0;
          instrucao_concluida = jump;
          reg_escrita         = (opcode == JAL);
          reg_dest            = (opcode == JAL) ? 2'd2 : 2'd0;
          mem_to_reg          = (opcode == JAL) ? 2'd2 : 2'd0;
          estado_d            = jump ? BUSCA : EXECUTA;
        end
        EXECUTA: begin
          ula_opcode = (opcode == BEQ) ? 2'd3 :
                       (opcode == SLTI) ? 2'd2 :
                       (opcode == ADDI || mem_op) ? 2'd1 : 2'd0;
          ula_src    = (opcode == ADDI) || (opcode == SLTI) || mem_op;
          sign_zero  = (opcode != SLTI);
          // Branch decision is taken from the live ULA zero flag in this same cycle.
          pc_escrita          = (opcode == BEQ) && zero;
          pc_fonte            = (opcode == BEQ) ? 2'd1 : 2'd0;
          instrucao_concluida = (opcode == BEQ);
          estado_d            = reg_op ? ESCRITA : mem_op ? MEMORIA : BUSCA;
        end
        MEMORIA: begin
          iord                = 1'b1;
          ula_src             = 1'b1;
          ula_opcode          = 2'd1;
          mem_leitura         = (opcode == LW);
          mem_escrita         = (opcode == SW);
          instrucao_concluida = mem_pronta && (opcode == SW);
          estado_d            = !mem_pronta ? MEMORIA : (opcode == LW) ? ESCRITA : BUSCA;
        end
        ESCRITA: begin
          reg_escrita         = 1'b1;
          instrucao_concluida = 1'b1;
          reg_dest            = (opcode == TIPO_R) ? 2'd0 : 2'd1;
          mem_to_reg          = (opcode == LW) ? 2'd1 : 2'd0;
        end
        default: estado_d = BUSCA;
      endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: directed self-checking bench for controle_multiciclo
module tb_controle_multiciclo;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       mem_pronta = 1'b1;
  logic       pc_escrita, ir_escrita, reg_escrita, mem_leitura, mem_escrita, ula_src, iord, sign_zero;
  logic [1:0] ula_opcode, reg_dest, mem_to_reg, pc_fonte;
  logic [2:0] estado;
  logic       instrucao_concluida;
  int n_tests = 0;
  int n_fail = 0;
  controle_multiciclo dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_pronta(mem_pronta),
    .pc_escrita(pc_escrita), .ir_escrita(ir_escrita), .reg_escrita(reg_escrita),
    .mem_leitura(mem_leitura), .mem_escrita(mem_escrita), .ula_src(ula_src), .iord(iord),
    .sign_zero(sign_zero), .ula_opcode(ula_opcode), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .pc_fonte(pc_fonte), .estado(estado),
    .instrucao_concluida(instrucao_concluida)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #2;
  endtask
  initial begin
    #3;
    chk("rst_estado", 8'(estado), 8'd0);
    chk("rst_mem_leitura", 8'(mem_leitura), 8'd0);
    chk("rst_ir_escrita", 8'(ir_escrita), 8'd0);
    chk("rst_sign_zero", 8'(sign_zero), 8'd1);
    step;
    step;
    chk("rst_hold_estado", 8'(estado), 8'd0);
    chk("rst_hold_pc_escrita", 8'(pc_escrita), 8'd0);
    reset = 1'b1;
    #1;
    chk("r_busca_mem_leitura", 8'(mem_leitura), 8'd1);
    chk("r_busca_ir_escrita", 8'(ir_escrita), 8'd1);
    chk("r_busca_pc_escrita", 8'(pc_escrita), 8'd1);
    step;
    chk("r_dec_estado", 8'(estado), 8'd1);
    chk("r_dec_reg_escrita", 8'(reg_escrita), 8'd0);
    step;
    chk("r_exe_estado", 8'(estado), 8'd2);
    chk("r_exe_ula_opcode", 8'(ula_opcode), 8'd0);
    chk("r_exe_ula_src", 8'(ula_src), 8'd0);
    chk("r_exe_reg_escrita", 8'(reg_escrita), 8'd0);
    step;
    chk("r_esc_estado", 8'(estado), 8'd4);
    chk("r_esc_reg_escrita", 8'(reg_escrita), 8'd1);
    chk("r_esc_concluida", 8'(instrucao_concluida), 8'd1);
    chk("r_esc_reg_dest", 8'(reg_dest), 8'd0);
    step;
    chk("r_end_estado", 8'(estado), 8'd0);
    chk("r_end_concluida", 8'(instrucao_concluida), 8'd0);
    opcode = 3'b011;
    step;
    chk("lw_dec_estado", 8'(estado), 8'd1);
    step;
    chk("lw_exe_ula_src", 8'(ula_src), 8'd1);
    chk("lw_exe_ula_opcode", 8'(ula_opcode), 8'd1);
    mem_pronta = 1'b0;
    step;
    chk("lw_mem1_estado", 8'(estado), 8'd3);
    chk("lw_mem1_mem_leitura", 8'(mem_leitura), 8'd1);
    chk("lw_mem1_iord", 8'(iord), 8'd1);
    step;
    chk("lw_mem2_estado", 8'(estado), 8'd3);
    step;
    chk("lw_mem3_estado", 8'(estado), 8'd3);
    chk("lw_mem3_mem_leitura", 8'(mem_leitura), 8'd1);
    chk("lw_mem3_mem_escrita", 8'(mem_escrita), 8'd0);
    mem_pronta = 1'b1;
    #1;
    chk("lw_mem4_concluida", 8'(instrucao_concluida), 8'd0);
    step;
    chk("lw_esc_estado", 8'(estado), 8'd4);
    chk("lw_esc_mem_to_reg", 8'(mem_to_reg), 8'd1);
    chk("lw_esc_reg_dest", 8'(reg_dest), 8'd1);
    step;
    chk("lw_end_estado", 8'(estado), 8'd0);
    opcode = 3'b101;
    step;
    step;
    zero = 1'b1;
    #1;
    chk("beq_exe_estado", 8'(estado), 8'd2);
    chk("beq_z1_pc_escrita", 8'(pc_escrita), 8'd1);
    chk("beq_z1_pc_fonte", 8'(pc_fonte), 8'd1);
    chk("beq_ula_opcode", 8'(ula_opcode), 8'd3);
    chk("beq_concluida", 8'(instrucao_concluida), 8'd1);
    zero = 1'b0;
    #1;
    chk("beq_z0_pc_escrita", 8'(pc_escrita), 8'd0);
    step;
    chk("beq_end_estado", 8'(estado), 8'd0);
    opcode = 3'b111;
    step;
    chk("jal_dec_estado", 8'(estado), 8'd1);
    chk("jal_reg_dest", 8'(reg_dest), 8'd2);
    chk("jal_mem_to_reg", 8'(mem_to_reg), 8'd2);
    chk("jal_pc_fonte", 8'(pc_fonte), 8'd2);
    chk("jal_reg_escrita", 8'(reg_escrita), 8'd1);
    chk("jal_pc_escrita", 8'(pc_escrita), 8'd1);
    step;
    chk("jal_end_estado", 8'(estado), 8'd0);
    opcode = 3'b110;
    step;
    chk("j_reg_escrita", 8'(reg_escrita), 8'd0);
    chk("j_pc_fonte", 8'(pc_fonte), 8'd2);
    step;
    chk("j_end_estado", 8'(estado), 8'd0);
    opcode = 3'b010;
    step;
    chk("slti_dec_sign_zero", 8'(sign_zero), 8'd1);
    step;
    chk("slti_exe_sign_zero", 8'(sign_zero), 8'd0);
    chk("slti_exe_ula_opcode", 8'(ula_opcode), 8'd2);
    chk("slti_exe_ula_src", 8'(ula_src), 8'd1);
    step;
    chk("slti_esc_sign_zero", 8'(sign_zero), 8'd1);
    chk("slti_esc_reg_dest", 8'(reg_dest), 8'd1);
    chk("slti_esc_mem_to_reg", 8'(mem_to_reg), 8'd0);
    step;
    chk("slti_end_estado", 8'(estado), 8'd0);
    opcode = 3'b100;
    step;
    step;
    chk("sw_exe_ula_opcode", 8'(ula_opcode), 8'd1);
    mem_pronta = 1'b0;
    step;
    chk("sw_mem_estado", 8'(estado), 8'd3);
    chk("sw_mem_mem_escrita", 8'(mem_escrita), 8'd1);
    chk("sw_mem_mem_leitura", 8'(mem_leitura), 8'd0);
    chk("sw_mem_reg_escrita", 8'(reg_escrita), 8'd0);
    step;
    chk("sw_wait_estado", 8'(estado), 8'd3);
    reset = 1'b0;
    #1;
    chk("sw_rst_estado", 8'(estado), 8'd0);
    chk("sw_rst_mem_escrita", 8'(mem_escrita), 8'd0);
    chk("sw_rst_mem_leitura", 8'(mem_leitura), 8'd0);
    mem_pronta = 1'b1;
    reset = 1'b1;
    #1;
    chk("post_rst_mem_leitura", 8'(mem_leitura), 8'd1);
    chk("post_rst_mem_escrita", 8'(mem_escrita), 8'd0);
    step;
    chk("post_rst_dec_estado", 8'(estado), 8'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameters SHALL be TIPO_R=3'b000, ADDI=3'b001, SLTI=3'b010, LW=3'b011, SW=3'b100, BEQ=3'b101, J=3'b110, JAL=3'b111 (opcode encodings).
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 opcode  in  3  opcode field of the instruction register; stable from DECODIFICA until the next BUSCA.
REQ-005 zero  in  1  ULA zero flag.
REQ-006 mem_pronta  in  1  memory ready; completes a read or write access on the cycle it is 1.
REQ-007 pc_escrita, ir_escrita, reg_escrita, mem_leitura, mem_escrita, ula_src, iord  out  1 each  PC write, IR write, register file write, memory read, memory write, ULA B = immediate, memory address = ULA result (0 = PC).
REQ-008 sign_zero  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
REQ-009 ula_opcode, reg_dest, mem_to_reg, pc_fonte  out  2 each  ULA op class, destination register select, writeback select, PC source (0 = PC+4, 1 = branch target, 2 = jump target).
REQ-010 estado  out  3  current state; instrucao_concluida  out  1  one-cycle pulse when an instruction retires.

Function
REQ-011 States SHALL be BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4; codes 5-7 SHALL go to BUSCA on the next edge with all outputs at default.
REQ-012 Default output values in every state, unless overridden below: all 1-bit outputs 0 except sign_zero=1; all 2-bit outputs 0.
REQ-013 BUSCA: mem_leitura=1, iord=0; hold while mem_pronta=0; on mem_pronta=1 same cycle: ir_escrita=1, pc_escrita=1, pc_fonte=0; next state DECODIFICA.
REQ-014 DECODIFICA, J: pc_escrita=1, pc_fonte=2, instrucao_concluida=1; next state BUSCA.
REQ-015 DECODIFICA, JAL: as J, plus reg_escrita=1, reg_dest=2, mem_to_reg=2; next state BUSCA.
REQ-016 DECODIFICA, all other opcodes: no writes; next state EXECUTA.
REQ-017 EXECUTA: ula_opcode = 0 for TIPO_R, 1 for ADDI/LW/SW, 2 for SLTI, 3 for BEQ; ula_src=1 for ADDI/SLTI/LW/SW; sign_zero=0 only for SLTI.
REQ-018 EXECUTA, next state: ESCRITA for TIPO_R/ADDI/SLTI; MEMORIA for LW/SW.
REQ-019 EXECUTA, BEQ: pc_escrita = zero (combinational, same cycle), pc_fonte=1, instrucao_concluida=1; next state BUSCA.
REQ-020 MEMORIA: iord=1, ula_src=1, ula_opcode=1; mem_leitura=1 for LW, mem_escrita=1 for SW; hold while mem_pronta=0.
REQ-021 MEMORIA, mem_pronta=1: LW goes to ESCRITA; SW asserts instrucao_concluida=1 and goes to BUSCA.
REQ-022 ESCRITA: reg_escrita=1, instrucao_concluida=1; next state BUSCA.
REQ-023 ESCRITA, select values: TIPO_R reg_dest=0, mem_to_reg=0; ADDI/SLTI reg_dest=1, mem_to_reg=0; LW reg_dest=1, mem_to_reg=1.
REQ-024 Outputs SHALL be combinational from state, opcode, zero and mem_pronta; mem_leitura/mem_escrita SHALL stay asserted and unchanged for the whole wait.
REQ-025 Cycles per instruction with mem_pronta held at 1: J/JAL 2, BEQ 3, TIPO_R/ADDI/SLTI 4, SW 4, LW 5; each cycle of mem_pronta=0 adds one cycle.

Reset
REQ-026 reset=0 SHALL force state BUSCA asynchronously and hold all outputs at the REQ-012 defaults (mem_leitura=0, estado=0) while asserted, including mid-instruction or mid-memory-wait.
REQ-027 On the first cycle after reset is released, the block SHALL be in BUSCA with mem_leitura=1; no partial instruction SHALL resume.

Verification
REQ-028 Reset release, mem_pronta=1, opcode=TIPO_R -> estado 0,1,2,4,0; reg_escrita=1 only in state 4; one instrucao_concluida pulse.
REQ-029 LW with mem_pronta=0 for 3 cycles in MEMORIA -> estado held at 3 with mem_leitura=1, iord=1; then ESCRITA with mem_to_reg=1; 8 cycles total.
REQ-030 BEQ with zero=1 -> pc_escrita=1, pc_fonte=1 in EXECUTA; with zero=0 -> pc_escrita=0; both return to BUSCA.
REQ-031 JAL -> in DECODIFICA: reg_dest=2, mem_to_reg=2, pc_fonte=2, reg_escrita=1, pc_escrita=1; 2 cycles total.
REQ-032 SLTI -> sign_zero=0 in EXECUTA only; SW -> mem_escrita=1 in MEMORIA, reg_escrita never 1.
REQ-033 reset=0 asserted mid-MEMORIA (SW, mem_pronta=0) -> estado=0, mem_escrita=0 immediately, without waiting for a clock edge.
